rob_commit: RTL

//  Commit stage directly downstream of the 32-entry ROB. Inspects the ROB head every cycle and

---
 rtl/rob_commit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rob_commit.sv
// Commit stage for the 32-entry ROB. Retires the head in program order, releases stores
// to the data cache, and triggers mispredict flush and PC redirect.
module rob_commit #(
    parameter int unsigned FLUSH_HOLD = 1,
    parameter int unsigned CNT_W      = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             head_valid_i,
    input  logic             head_done_i,
    input  logic             head_regf_we_i,
    input  logic [4:0]       head_rd_addr_i,
    input  logic [31:0]      head_rd_data_i,
    input  logic             head_is_br_i,
    input  logic             head_br_en_i,
    input  logic             head_pred_i,
    input  logic [31:0]      head_pc_new_i,
    input  logic             head_is_st_i,
    input  logic [31:0]      head_mem_addr_i,
    input  logic [3:0]       head_wmask_i,
    input  logic [31:0]      head_wdata_i,
    output logic             dequeue_o,
    output logic             regf_we_o,
    output logic [4:0]       regf_rd_addr_o,
    output logic [31:0]      regf_rd_data_o,
    output logic             st_req_o,
    output logic [31:0]      st_addr_o,
    output logic [3:0]       st_wmask_o,
    output logic [31:0]      st_wdata_o,
    input  logic             st_ready_i,
    input  logic             st_ack_i,
    output logic             flush_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] retired_cnt_o,
    output logic [31:0]      mispred_cnt_o
);

    localparam int unsigned HOLD_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;

    typedef enum logic [1:0] {StRun, StFlush, StStReq, StStResp} state_e;

    state_e             r_state;
    logic [HOLD_W-1:0]  r_hold;
    logic               r_st_req;
    logic [31:0]        r_st_addr;
    logic [3:0]         r_st_wmask;
    logic [31:0]        r_st_wdata;
    logic               r_flush;
    logic [31:0]        r_redirect_pc;
    logic [CNT_W-1:0]   r_retired;
    logic [31:0]        r_mispred;

    logic w_commit_ok;
    logic w_mispred;

    assign w_commit_ok = head_valid_i & head_done_i;
    assign w_mispred   = head_is_br_i & (head_br_en_i != head_pred_i);

    // Zero-latency retirement path; a mispredicting head is popped by the ROB flush instead.
    always_comb begin
        dequeue_o      = 1'b0;
        regf_we_o      = 1'b0;
        regf_rd_addr_o = '0;
        regf_rd_data_o = '0;
        if (!rst) begin
            unique case (r_state)
                StRun: begin
                    if (w_commit_ok && !head_is_st_i) begin
                        dequeue_o      = !w_mispred;
                        regf_we_o      = head_regf_we_i && (head_rd_addr_i != 5'd0);
                        regf_rd_addr_o = head_rd_addr_i;
                        regf_rd_data_o = head_rd_data_i;
                    end
                end
                StStResp: dequeue_o = st_ack_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StRun;
            r_hold        <= '0;
            r_st_req      <= 1'b0;
            r_st_addr     <= '0;
            r_st_wmask    <= '0;
            r_st_wdata    <= '0;
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
            r_retired     <= '0;
            r_mispred     <= '0;
        end else begin
            r_flush <= 1'b0;
            unique case (r_state)
                StRun: begin
                    if (w_commit_ok) begin
                        if (head_is_st_i) begin
                            r_st_req   <= 1'b1;
                            r_st_addr  <= head_mem_addr_i;
                            r_st_wmask <= head_wmask_i;
                            r_st_wdata <= head_wdata_i;
                            r_state    <= StStReq;
                        end else begin
                            r_retired <= r_retired + CNT_W'(1);
                            if (w_mispred) begin
                                r_flush       <= 1'b1;
                                r_redirect_pc <= head_pc_new_i;
                                r_mispred     <= r_mispred + 32'd1;
                                r_hold        <= HOLD_W'(FLUSH_HOLD - 1);
                                r_state       <= StFlush;
                            end
                        end
                    end
                end
                StFlush: begin
                    if (r_hold == '0) begin
                        r_state <= StRun;
                    end else begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                StStReq: begin
                    if (st_ready_i) begin
                        r_st_req <= 1'b0;
                        r_state  <= StStResp;
                    end
                end
                StStResp: begin
                    if (st_ack_i) begin
                        r_retired <= r_retired + CNT_W'(1);
                        r_state   <= StRun;
                    end
                end
                default: r_state <= StRun;
            endcase
        end
    end

    assign st_req_o      = r_st_req;
    assign st_addr_o     = r_st_addr;
    assign st_wmask_o    = r_st_wmask;
    assign st_wdata_o    = r_st_wdata;
    assign flush_o       = r_flush;
    assign redirect_pc_o = r_redirect_pc;
    assign retired_cnt_o = r_retired;
    assign mispred_cnt_o = r_mispred;

endmodule
